// File: rtl/pa_fmau_norm_shifter_single.sv
// Two-stage leading-zero normalizer for the single-precision FMA datapath, valid/ready with flush.
// Build option: define FMAU_NORM_SUBNORM_EN for gradual underflow; default flushes tiny results to zero.
module pa_fmau_norm_shifter_single #(
  parameter int DATA_WIDTH = 53,
  parameter int EXP_WIDTH  = 10
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ex_flush,
  input  logic                  norm_in_vld,
  output logic                  norm_in_rdy,
  input  logic [DATA_WIDTH-1:0] norm_in_data,
  input  logic [EXP_WIDTH-1:0]  norm_in_expnt,
  output logic                  norm_out_vld,
  input  logic                  norm_out_rdy,
  output logic [23:0]           norm_out_frac,
  output logic                  norm_out_guard,
  output logic                  norm_out_sticky,
  output logic [EXP_WIDTH-1:0]  norm_out_expnt,
  output logic                  norm_out_zero,
  output logic                  norm_out_tiny
);

  localparam int MW  = DATA_WIDTH - 1;        // hidden-bit index + 1 = width of shifted value
  localparam int LZW = $clog2(DATA_WIDTH);
  localparam logic signed [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(1);

  // ---------------- handshake ----------------
  logic                  s1_vld_q, s1_vld_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [EXP_WIDTH-1:0]  s1_expnt_q;
  logic                  s1_adv, in_fire, s2_load;

  assign s1_adv      = !s2_vld_q || norm_out_rdy;
  assign norm_in_rdy = !s1_vld_q || s1_adv;
  assign in_fire     = norm_in_vld && norm_in_rdy;
  assign s2_load     = s1_vld_q && s1_adv;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (ex_flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (in_fire)      s1_vld_d = 1'b1;
      else if (s1_adv)  s1_vld_d = 1'b0;
      if (s1_adv)       s2_vld_d = s1_vld_q;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_expnt_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (in_fire) begin
        s1_data_q  <= norm_in_data;
        s1_expnt_q <= norm_in_expnt;
      end
    end
  end

  // ---------------- S1 normalize ----------------
  logic [LZW-1:0]               lzc, shamt;
  logic                         carry, nz, uflow, drop;
  logic signed [EXP_WIDTH-1:0]  exp_in, exp_norm, exp_carry;
  logic [MW-1:0]                v;

  // Highest set bit wins; an all-zero field leaves lzc = MW.
  always_comb begin
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++)
      if (s1_data_q[i]) lzc = LZW'(MW - 1 - i);
  end

  assign carry     = s1_data_q[MW];
  assign nz        = |s1_data_q;
  assign exp_in    = s1_expnt_q;
  assign exp_norm  = exp_in - EXP_WIDTH'(lzc);
  assign exp_carry = exp_in + EXP_ONE;
  assign uflow     = nz && !carry && (exp_norm < EXP_ONE);
  assign drop      = carry && s1_data_q[0];

  always_comb begin
    shamt = lzc;
`ifdef FMAU_NORM_SUBNORM_EN
    // Stop at exponent 1 so the result lands in the denormal encoding.
    if (uflow) shamt = (exp_in > EXP_ONE) ? LZW'(exp_in - EXP_ONE) : '0;
`endif
  end

  assign v = carry ? s1_data_q[MW:1] : (s1_data_q[MW-1:0] << shamt);

  logic [23:0]          frac_d;
  logic                 guard_d, sticky_d, zero_d, tiny_d;
  logic [EXP_WIDTH-1:0] expnt_d;

  always_comb begin
    frac_d   = v[MW-1 -: 24];
    guard_d  = v[MW-25];
    sticky_d = (|v[MW-26:0]) | drop;
    zero_d   = !nz;
    tiny_d   = nz && (carry ? (exp_carry < EXP_ONE) : uflow);
    if (!nz || uflow) expnt_d = '0;
    else if (carry)   expnt_d = exp_carry;
    else              expnt_d = exp_norm;
`ifndef FMAU_NORM_SUBNORM_EN
    if (uflow) begin
      frac_d   = '0;
      guard_d  = 1'b0;
      sticky_d = 1'b0;
      zero_d   = 1'b1;
    end
`endif
  end

  // ---------------- S2 register ----------------
  logic [23:0]          frac_q;
  logic                 guard_q, sticky_q, zero_q, tiny_q;
  logic [EXP_WIDTH-1:0] expnt_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s2_vld_q <= 1'b0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      expnt_q  <= '0;
      zero_q   <= 1'b0;
      tiny_q   <= 1'b0;
    end else begin
      s2_vld_q <= s2_vld_d;
      if (s2_load) begin
        frac_q   <= frac_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
        expnt_q  <= expnt_d;
        zero_q   <= zero_d;
        tiny_q   <= tiny_d;
      end
    end
  end

  assign norm_out_vld    = s2_vld_q;
  assign norm_out_frac   = frac_q;
  assign norm_out_guard  = guard_q;
  assign norm_out_sticky = sticky_q;
  assign norm_out_expnt  = expnt_q;
  assign norm_out_zero   = zero_q;
  assign norm_out_tiny   = tiny_q;

endmodule
